fm_gate_ctrl: RTL and testbench

//  Measurement sequencer for the frequency-meter counter datapath. Drives the counter's clear,

---
 rtl/fm_gate_ctrl_if.sv | 51 +++++
 rtl/fm_gate_ctrl.sv | 249 ++++++++++++++++++++++++
 tb/tb_fm_gate_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/fm_gate_ctrl_if.sv
// ---------------------------------------------------------------------------
// fm_gate_ctrl_if
//   Bundles the front-panel controls, the counter status inputs and the
//   sequencer strobes of the frequency-meter gate controller.
//   master: the side driving run/range controls and counter status
//           (front panel + counter model).
//   slave : the gate controller itself.
// ---------------------------------------------------------------------------
interface fm_gate_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             run;
    logic             auto_en;
    logic [1:0]       range_sel;
    logic             cnt_ovf;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_clr;
    logic             cnt_en;
    logic             latch_en;
    logic [1:0]       range;
    logic             ovf_flag;
    logic             busy;

    modport master (
        output run,
        output auto_en,
        output range_sel,
        output cnt_ovf,
        output cnt_val,
        input  cnt_clr,
        input  cnt_en,
        input  latch_en,
        input  range,
        input  ovf_flag,
        input  busy
    );

    modport slave (
        input  run,
        input  auto_en,
        input  range_sel,
        input  cnt_ovf,
        input  cnt_val,
        output cnt_clr,
        output cnt_en,
        output latch_en,
        output range,
        output ovf_flag,
        output busy
    );
endinterface

// File: rtl/fm_gate_ctrl.sv
// ---------------------------------------------------------------------------
// fm_gate_ctrl
//   Measurement sequencer for the frequency-meter counter datapath.
//   Cycle: IDLE -> CLEAR -> GATE -> LATCH -> HOLD -> (CLEAR | IDLE).
//   The strobes cnt_clr / cnt_en / busy are registered from the next state,
//   so they are high exactly while the FSM sits in CLEAR / GATE / non-IDLE.
//   The LATCH state is a one-cycle decision slot: the counter has received
//   its last enabled cycle, so cnt_val/cnt_ovf are final there. When a result
//   is accepted, latch_en is registered on the LATCH->HOLD edge and is thus
//   high during the first HOLD cycle while the counter is frozen.
//   Auto-range: overflow below range 2 shifts to a shorter gate and
//   re-measures without latching; an under-range result shifts to a longer
//   gate for the next measurement.
//   Optional build macro FM_RANGE_HYST_EN: downshift only after two
//   consecutive under-range results at the same range.
//   Reset: CR, synchronous, active-high.
// ---------------------------------------------------------------------------
module fm_gate_ctrl #(
    parameter int CLR_CYC   = 50,
    parameter int GATE_L0   = 5000000,
    parameter int GATE_L1   = 500000,
    parameter int GATE_L2   = 50000,
    parameter int HOLD_CYC  = 450,
    parameter int CNT_W     = 16,
    parameter int UNDER_LIM = 1000,
    parameter int TMR_W     = 24
) (
    input  logic               clk,
    input  logic               CR,
    fm_gate_ctrl_if.slave      bus
);

    // Terminal timer values: each state lasts N cycles, timer runs 0..N-1.
    localparam logic [TMR_W-1:0] CLR_END   = TMR_W'(CLR_CYC - 1);
    localparam logic [TMR_W-1:0] GATE0_END = TMR_W'(GATE_L0 - 1);
    localparam logic [TMR_W-1:0] GATE1_END = TMR_W'(GATE_L1 - 1);
    localparam logic [TMR_W-1:0] GATE2_END = TMR_W'(GATE_L2 - 1);
    localparam logic [TMR_W-1:0] HOLD_END  = TMR_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] UNDER_V   = CNT_W'(UNDER_LIM);
    localparam logic [TMR_W-1:0] TMR_ZERO  = {TMR_W{1'b0}};
    localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1'b1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_GATE  = 3'd2,
        ST_LATCH = 3'd3,
        ST_HOLD  = 3'd4
    } state_t;

    // Manual range selection: code 3 maps onto the shortest gate.
    function automatic logic [1:0] clamp_range(input logic [1:0] sel);
        logic [1:0] res;
        if (sel == 2'd3) begin
            res = 2'd2;
        end else begin
            res = sel;
        end
        return res;
    endfunction

    state_t           state_r;
    state_t           state_s;
    logic [TMR_W-1:0] timer_r;
    logic [TMR_W-1:0] timer_s;
    logic [TMR_W-1:0] gate_end_s;
    logic [1:0]       range_r;
    logic [1:0]       range_s;
    logic             ovf_flag_r;
    logic             ovf_flag_s;
    logic             latch_s;
    logic             cnt_clr_r;
    logic             cnt_en_r;
    logic             latch_en_r;
    logic             busy_r;
    logic             remeasure_s;
    logic             under_s;
`ifdef FM_RANGE_HYST_EN
    logic [1:0]       streak_r;
    logic [1:0]       streak_s;
`endif

    // Gate length for the range currently in use.
    always_comb begin
        gate_end_s = GATE2_END;
        case (range_r)
            2'd0:    gate_end_s = GATE0_END;
            2'd1:    gate_end_s = GATE1_END;
            default: gate_end_s = GATE2_END;
        endcase
    end

    // Auto-range result classification at the LATCH decision.
    always_comb begin
        remeasure_s = bus.auto_en && bus.cnt_ovf && (range_r != 2'd2);
        under_s     = bus.auto_en && !bus.cnt_ovf &&
                      (bus.cnt_val < UNDER_V) && (range_r != 2'd0);
    end

    // Next-state, timer, range and result-flag decisions.
    always_comb begin
        state_s    = state_r;
        timer_s    = timer_r + TMR_ONE;
        range_s    = range_r;
        ovf_flag_s = ovf_flag_r;
        latch_s    = 1'b0;
`ifdef FM_RANGE_HYST_EN
        streak_s   = streak_r;
`endif
        case (state_r)
            ST_IDLE: begin
                timer_s = TMR_ZERO;
                if (bus.run) begin
                    state_s = ST_CLEAR;
                    if (!bus.auto_en) begin
                        range_s = clamp_range(bus.range_sel);
                    end else begin
                        range_s = range_r;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (timer_r == CLR_END) begin
                    state_s = ST_GATE;
                    timer_s = TMR_ZERO;
                end else begin
                    state_s = ST_CLEAR;
                end
            end
            ST_GATE: begin
                if (timer_r == gate_end_s) begin
                    state_s = ST_LATCH;
                    timer_s = TMR_ZERO;
                end else begin
                    state_s = ST_GATE;
                end
            end
            ST_LATCH: begin
                timer_s = TMR_ZERO;
                if (remeasure_s) begin
                    // Overflowed below the shortest gate: shorten and retry.
                    state_s = ST_CLEAR;
                    range_s = range_r + 2'd1;
                end else begin
                    state_s    = ST_HOLD;
                    latch_s    = 1'b1;
                    ovf_flag_s = bus.cnt_ovf;
                    if (under_s) begin
`ifdef FM_RANGE_HYST_EN
                        if (streak_r == 2'd1) begin
                            range_s = range_r - 2'd1;
                        end else begin
                            streak_s = streak_r + 2'd1;
                        end
`else
                        range_s = range_r - 2'd1;
`endif
                    end else begin
`ifdef FM_RANGE_HYST_EN
                        streak_s = 2'd0;
`else
                        range_s = range_r;
`endif
                    end
                end
            end
            ST_HOLD: begin
                if (timer_r == HOLD_END) begin
                    timer_s = TMR_ZERO;
                    if (bus.run) begin
                        state_s = ST_CLEAR;
                        if (!bus.auto_en) begin
                            range_s = clamp_range(bus.range_sel);
                        end else begin
                            range_s = range_r;
                        end
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    state_s = ST_HOLD;
                end
            end
            default: begin
                state_s = ST_IDLE;
                timer_s = TMR_ZERO;
            end
        endcase
`ifdef FM_RANGE_HYST_EN
        // A streak only counts at one range; any range change restarts it.
        if (range_s != range_r) begin
            streak_s = 2'd0;
        end else begin
            streak_s = streak_s;
        end
`endif
    end

    // FSM state, timer and range registers.
    always_ff @(posedge clk) begin
        if (CR) begin
            state_r <= ST_IDLE;
            timer_r <= TMR_ZERO;
            range_r <= 2'd0;
        end else begin
            state_r <= state_s;
            timer_r <= timer_s;
            range_r <= range_s;
        end
    end

`ifdef FM_RANGE_HYST_EN
    // Consecutive under-range streak counter.
    always_ff @(posedge clk) begin
        if (CR) begin
            streak_r <= 2'd0;
        end else begin
            streak_r <= streak_s;
        end
    end
`endif

    // Registered strobes and status, aligned with the state they describe.
    always_ff @(posedge clk) begin
        if (CR) begin
            cnt_clr_r  <= 1'b0;
            cnt_en_r   <= 1'b0;
            latch_en_r <= 1'b0;
            busy_r     <= 1'b0;
            ovf_flag_r <= 1'b0;
        end else begin
            cnt_clr_r  <= (state_s == ST_CLEAR);
            cnt_en_r   <= (state_s == ST_GATE);
            latch_en_r <= latch_s;
            busy_r     <= (state_s != ST_IDLE);
            ovf_flag_r <= ovf_flag_s;
        end
    end

    assign bus.cnt_clr  = cnt_clr_r;
    assign bus.cnt_en   = cnt_en_r;
    assign bus.latch_en = latch_en_r;
    assign bus.range    = range_r;
    assign bus.ovf_flag = ovf_flag_r;
    assign bus.busy     = busy_r;

endmodule

// File: tb/tb_fm_gate_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fm_gate_ctrl
//   Directed bench for fm_gate_ctrl with short timing parameters
//   (CLR 2, gates 40/20/10, hold 3, under-range limit 100).
//   Expected strobe pattern per cycle after the run request edge:
//   2 x cnt_clr, GATE_L x cnt_en, 1 quiet LATCH slot, latch_en (first HOLD
//   cycle), 2 more quiet HOLD cycles, then the next CLEAR or IDLE.
// ---------------------------------------------------------------------------
module tb_fm_gate_ctrl;

    localparam logic [2:0] S_NONE = 3'b000;
    localparam logic [2:0] S_CLR  = 3'b100;
    localparam logic [2:0] S_EN   = 3'b010;
    localparam logic [2:0] S_LAT  = 3'b001;

    logic clk;
    logic CR;
    int   total;
    int   bad;

    fm_gate_ctrl_if #(.CNT_W(16)) bus ();

    fm_gate_ctrl #(
        .CLR_CYC   (2),
        .GATE_L0   (40),
        .GATE_L1   (20),
        .GATE_L2   (10),
        .HOLD_CYC  (3),
        .CNT_W     (16),
        .UNDER_LIM (100),
        .TMR_W     (24)
    ) dut (
        .clk (clk),
        .CR  (CR),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Check the strobe triple for n consecutive cycles, advancing one cycle each.
    task automatic phase(input int n, input logic [2:0] exp, input string tag);
        for (int i = 0; i < n; i++) begin
            chk(tag, {5'd0, bus.cnt_clr, bus.cnt_en, bus.latch_en}, {5'd0, exp});
            tick();
        end
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        CR            = 1'b1;
        bus.run       = 1'b0;
        bus.auto_en   = 1'b0;
        bus.range_sel = 2'd0;
        bus.cnt_ovf   = 1'b0;
        bus.cnt_val   = 16'd0;

        // 1: reset, then idle with run low
        tick();
        tick();
        chk("rst_strobes", {5'd0, bus.cnt_clr, bus.cnt_en, bus.latch_en}, 8'd0);
        chk("rst_range", {6'd0, bus.range}, 8'd0);
        chk("rst_busy", {7'd0, bus.busy}, 8'd0);
        chk("rst_ovf", {7'd0, bus.ovf_flag}, 8'd0);
        CR = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        phase(3, S_NONE, "idle_strobes");
        chk("idle_busy", {7'd0, bus.busy}, 8'd0);
        chk("idle_range", {6'd0, bus.range}, 8'd0);

        // 2: manual range 1, continuous
        bus.range_sel = 2'd1;
        bus.run       = 1'b1;
        tick();
        chk("t2_range", {6'd0, bus.range}, 8'd1);
        chk("t2_busy", {7'd0, bus.busy}, 8'd1);
        phase(2, S_CLR, "t2_clr");
        phase(20, S_EN, "t2_gate");
        phase(1, S_NONE, "t2_latch_slot");
        phase(1, S_LAT, "t2_latch");
        phase(2, S_NONE, "t2_hold");
        phase(2, S_CLR, "t2_clr_again");

        // 5: run drops mid-gate, cycle completes then IDLE
        phase(5, S_EN, "t5_gate_a");
        bus.run = 1'b0;
        phase(15, S_EN, "t5_gate_b");
        phase(1, S_NONE, "t5_latch_slot");
        chk("t5_ovf_flag", {7'd0, bus.ovf_flag}, 8'd0);
        phase(1, S_LAT, "t5_latch");
        phase(1, S_NONE, "t5_hold");
        chk("t5_busy_hold", {7'd0, bus.busy}, 8'd1);
        phase(1, S_NONE, "t5_hold_end");
        chk("t5_busy_idle", {7'd0, bus.busy}, 8'd0);
        phase(3, S_NONE, "t5_idle");
        chk("t5_busy_idle2", {7'd0, bus.busy}, 8'd0);

        // 3: auto-range overflow up-shifts, starting at manual range 3 -> 2? no: range 0
        bus.range_sel = 2'd0;
        bus.run       = 1'b1;
        tick();
        chk("t3_range0", {6'd0, bus.range}, 8'd0);
        phase(1, S_CLR, "t3_clr_a");
        bus.auto_en = 1'b1;
        bus.cnt_ovf = 1'b1;
        bus.cnt_val = 16'hFFFF;
        phase(1, S_CLR, "t3_clr_b");
        phase(40, S_EN, "t3_gate40");
        phase(1, S_NONE, "t3_latch_slot0");
        chk("t3_range1", {6'd0, bus.range}, 8'd1);
        phase(2, S_CLR, "t3_reclear1");
        phase(20, S_EN, "t3_gate20");
        phase(1, S_NONE, "t3_latch_slot1");
        chk("t3_range2", {6'd0, bus.range}, 8'd2);
        phase(2, S_CLR, "t3_reclear2");
        phase(10, S_EN, "t3_gate10");
        phase(1, S_NONE, "t3_latch_slot2");
        chk("t3_ovf_flag", {7'd0, bus.ovf_flag}, 8'd1);
        chk("t3_range_hold", {6'd0, bus.range}, 8'd2);
        phase(1, S_LAT, "t3_latch");
        phase(2, S_NONE, "t3_hold");

        // 4: under-range at range 2 down-shifts
        bus.cnt_ovf = 1'b0;
        bus.cnt_val = 16'd50;
        phase(2, S_CLR, "t4_clr");
        phase(10, S_EN, "t4_gate10");
        phase(1, S_NONE, "t4_latch_slot");
        chk("t4_ovf_flag", {7'd0, bus.ovf_flag}, 8'd0);
`ifdef FM_RANGE_HYST_EN
        chk("t4_range_first", {6'd0, bus.range}, 8'd2);
`else
        chk("t4_range_first", {6'd0, bus.range}, 8'd1);
`endif
        phase(1, S_LAT, "t4_latch");
        phase(2, S_NONE, "t4_hold");
        phase(2, S_CLR, "t4_clr2");
`ifdef FM_RANGE_HYST_EN
        phase(10, S_EN, "t4_gate10_again");
        phase(1, S_NONE, "t4_latch_slot2");
        chk("t4_range_second", {6'd0, bus.range}, 8'd1);
        phase(1, S_LAT, "t4_latch2");
        phase(2, S_NONE, "t4_hold2");
        phase(2, S_CLR, "t4_clr3");
`endif
        phase(20, S_EN, "t4_gate20");
        phase(1, S_NONE, "t4_latch_slot_r1");
        phase(1, S_LAT, "t4_latch_r1");
        phase(2, S_NONE, "t4_hold_r1");
        phase(2, S_CLR, "t4_clr_r1");

        // 6: CR pulse mid-gate
        phase(5, S_EN, "t6_gate");
        CR = 1'b1;
        tick();
        chk("t6_strobes", {5'd0, bus.cnt_clr, bus.cnt_en, bus.latch_en}, 8'd0);
        chk("t6_range", {6'd0, bus.range}, 8'd0);
        chk("t6_busy", {7'd0, bus.busy}, 8'd0);
        chk("t6_ovf", {7'd0, bus.ovf_flag}, 8'd0);
        CR = 1'b0;
        tick();
        chk("t6_busy_restart", {7'd0, bus.busy}, 8'd1);
        chk("t6_range_restart", {6'd0, bus.range}, 8'd0);
        bus.run = 1'b0;
        phase(2, S_CLR, "t6_clr");
        phase(40, S_EN, "t6_gate40");
        phase(1, S_NONE, "t6_latch_slot");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
